cardinal_nic_host_ctrl: RTL

Processor-side sequencer for cardinal_nic. It owns the NIC's memory-mapped port (nic_addr/nic_d_in/nic_d_out/nic_en/nic_en_wr) and time-multiplexes it between an injection queue and a single-entry ejection register. Each round it polls the NIC output status and writes a queued packet if the channel is free, then polls the input status and reads a packet if one is waiting. It sits between a PE/traffic source and one NIC, one instance per ring node.

---
 rtl/cardinal_nic_host_if.sv | 28 ++
 rtl/cardinal_nic_host_ctrl.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/cardinal_nic_host_if.sv
// Bundles the cardinal_nic_host_ctrl handshake signals: the traffic-source
// injection port, the sink ejection port and the NIC memory-mapped port.
interface cardinal_nic_host_if #(
  parameter int PACKET_SIZE = 64
);
  logic                   ctrl_en;
  logic                   tx_valid;
  logic                   tx_ready;
  logic [PACKET_SIZE-1:0] tx_data;
  logic                   rx_valid;
  logic                   rx_ready;
  logic [PACKET_SIZE-1:0] rx_data;
  logic [1:0]             nic_addr;
  logic [PACKET_SIZE-1:0] nic_d_in;
  logic [PACKET_SIZE-1:0] nic_d_out;
  logic                   nic_en;
  logic                   nic_en_wr;

  modport master (
    input  ctrl_en, tx_valid, tx_data, rx_ready, nic_d_out,
    output tx_ready, rx_valid, rx_data, nic_addr, nic_d_in, nic_en, nic_en_wr
  );

  modport slave (
    output ctrl_en, tx_valid, tx_data, rx_ready, nic_d_out,
    input  tx_ready, rx_valid, rx_data, nic_addr, nic_d_in, nic_en, nic_en_wr
  );
endinterface

// File: rtl/cardinal_nic_host_ctrl.sv
// Processor-side sequencer for one cardinal_nic: time-multiplexes the NIC port
// between an injection FIFO (poll out-status, write) and an ejection register (poll in-status, read).
module cardinal_nic_host_ctrl #(
  parameter int PACKET_SIZE = 64,
  parameter int TX_DEPTH    = 4,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  cardinal_nic_host_if.master  bus,
  output logic [CNT_WIDTH-1:0] tx_sent_cnt,
  output logic [CNT_WIDTH-1:0] rx_recv_cnt,
  output logic                 ctrl_idle
);

  localparam int AW = (TX_DEPTH > 1) ? $clog2(TX_DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FIFO_FULL = CW'(TX_DEPTH);

  typedef enum logic [2:0] {
    IDLE,
    TX_POLL,
    TX_WRITE,
    RX_POLL,
    RX_READ
  } state_t;

  state_t state, state_nxt;

  logic [PACKET_SIZE-1:0] fifo_mem [TX_DEPTH];
  logic [AW-1:0]          wr_ptr, rd_ptr;
  logic [CW-1:0]          count;
  logic                   push, pop, fifo_empty, status_bit;

  logic                   rx_valid_q;
  logic [PACKET_SIZE-1:0] rx_data_q;
  logic                   nic_en_c, nic_en_wr_c;
  logic [1:0]             nic_addr_c;
  logic [PACKET_SIZE-1:0] nic_d_in_c;

  assign status_bit    = bus.nic_d_out[PACKET_SIZE-1];
  assign fifo_empty    = (count == '0);
  // Ready comes only from the registered count, so a pop while full does not raise it.
  assign bus.tx_ready  = (count != FIFO_FULL);
  assign push          = bus.tx_valid && bus.tx_ready;
  assign pop           = (state == TX_WRITE);

  assign bus.rx_valid  = rx_valid_q;
  assign bus.rx_data   = rx_data_q;
  assign bus.nic_en    = nic_en_c;
  assign bus.nic_en_wr = nic_en_wr_c;
  assign bus.nic_addr  = nic_addr_c;
  assign bus.nic_d_in  = nic_d_in_c;
  assign ctrl_idle     = (state == IDLE);

  // Next state plus Moore decode of the NIC port
  always_comb begin
    state_nxt   = state;
    nic_en_c    = 1'b0;
    nic_en_wr_c = 1'b0;
    nic_addr_c  = 2'b00;
    nic_d_in_c  = '0;
    unique case (state)
      IDLE: begin
        if (bus.ctrl_en) state_nxt = TX_POLL;
      end
      TX_POLL: begin
        nic_en_c   = 1'b1;
        nic_addr_c = 2'b11;
        state_nxt  = (!status_bit && !fifo_empty) ? TX_WRITE : RX_POLL;
      end
      TX_WRITE: begin
        nic_en_c    = 1'b1;
        nic_en_wr_c = 1'b1;
        nic_addr_c  = 2'b10;
        nic_d_in_c  = fifo_mem[rd_ptr];
        state_nxt   = RX_POLL;
      end
      RX_POLL: begin
        nic_en_c   = 1'b1;
        nic_addr_c = 2'b01;
        if (status_bit && !rx_valid_q) state_nxt = RX_READ;
        else                           state_nxt = bus.ctrl_en ? TX_POLL : IDLE;
      end
      RX_READ: begin
        nic_en_c   = 1'b1;
        nic_addr_c = 2'b00;
        state_nxt  = bus.ctrl_en ? TX_POLL : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Injection FIFO control; the write cycle is only entered with a non-empty FIFO
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= bus.tx_data;
  end

  // rx_valid is always low in RX_READ, so a load never overwrites an unconsumed packet
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_valid_q <= 1'b0;
      rx_data_q  <= '0;
    end else if (state == RX_READ) begin
      rx_valid_q <= 1'b1;
      rx_data_q  <= bus.nic_d_out;
    end else if (rx_valid_q && bus.rx_ready) begin
      rx_valid_q <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tx_sent_cnt <= '0;
      rx_recv_cnt <= '0;
    end else begin
      if (state == TX_WRITE) tx_sent_cnt <= tx_sent_cnt + CNT_WIDTH'(1);
      if (state == RX_READ)  rx_recv_cnt <= rx_recv_cnt + CNT_WIDTH'(1);
    end
  end

endmodule
